fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared pipeline types for the front end: address/instruction widths and
// the {pc, inst} entry carried from fetch to decode.
package fetch_pkg;

  localparam int WADDR_W = 62;
  localparam int INST_W  = 32;

  typedef struct packed {
    logic [63:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer between the memory read port and decode.
// Flush wins over push/pop; storage is not reset, consumers gate on count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [ENTRY_W-1:0]           push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [ENTRY_W-1:0]           head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= push_data;
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: sequential PC, one-cycle memory read port, a small
// buffer toward decode, redirect flush and halt/stall handling.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:2] mem_raddr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        d_stall,
  input  logic        halt,
  output logic        f_valid,
  output logic [31:0] f_inst,
  output logic [63:0] f_pc
);

  logic [WADDR_W-1:0]         pc;
  logic [WADDR_W-1:0]         inflight_pc;
  logic                       inflight;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic                       push;
  logic                       pop;
  logic                       issue;
  fetch_entry_t               push_entry;
  fetch_entry_t               head_entry;
  logic [ENTRY_W-1:0]         head_bits;
  logic                       redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign mem_raddr = pc;
  assign f_valid   = (fifo_count != '0);
  assign pop       = f_valid && !d_stall;
  assign push      = inflight && !redirect_valid;

  // Buffered plus in-flight never exceeds DEPTH, so a push into a full
  // buffer is always paired with a pop.
  assign issue = !halt && !redirect_valid &&
                 (((int'(fifo_count) + int'(inflight)) < DEPTH) || pop);

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = {inflight_pc, 2'b00};
    push_entry.inst = mem_rdata;
  end

  assign head_entry = fetch_entry_t'(head_bits);
  assign f_inst     = f_valid ? head_entry.inst : '0;
  assign f_pc       = f_valid ? head_entry.pc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC[63:2];
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc[63:2];
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + 1'b1;
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head_data (head_bits)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing scenarios plus randomized stall,
// halt and redirect traffic checked against an in-order program-stream model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:2] mem_raddr;
  logic [31:0] mem_rdata = '0;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        d_stall;
  logic        halt;
  logic        f_valid;
  logic [31:0] f_inst;
  logic [63:0] f_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] next_pc;
  logic [63:0] exp_pc;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_pc;
  logic [31:0] prev_inst;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .d_stall        (d_stall),
    .halt           (halt),
    .f_valid        (f_valid),
    .f_inst         (f_inst),
    .f_pc           (f_pc)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // Instruction memory: contents are a fixed function of the word address.
  function automatic logic [31:0] inst_of(input logic [61:0] w);
    return (w[31:0] * 32'h9E3779B1) ^ {w[61:32], 2'b01};
  endfunction

  always @(posedge clk) mem_rdata <= inst_of(mem_raddr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected program order: sequential words from the last restart point.
  function automatic void top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 64'd4;
    end
  endfunction

  function automatic void reset_stream(input logic [63:0] start);
    exp_q.delete();
    next_pc = {start[63:2], 2'b00};
    top_up();
  endfunction

  // scoreboard monitor: every instruction accepted by decode must be next in order
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      check("no_push_when_full",
            64'(dut.push && (int'(dut.fifo_count) == DEPTH) && !dut.pop), 64'd0);
      if (prev_hold && f_valid) begin
        check("stall_hold_pc", f_pc, prev_pc);
        check("stall_hold_inst", 64'(f_inst), 64'(prev_inst));
      end
      if (!redirect_valid && f_valid && !d_stall) begin
        check("exp_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_pc = exp_q.pop_front();
          check("f_pc", f_pc, exp_pc);
          check("f_inst", 64'(f_inst), 64'(inst_of(exp_pc[63:2])));
          top_up();
        end
      end
      prev_hold = f_valid && d_stall && !redirect_valid;
      prev_pc   = f_pc;
      prev_inst = f_inst;
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic release_and_check();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("boot_raddr0", 64'(mem_raddr), 64'(RESET_PC[63:2]));
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check("boot_raddr", 64'(mem_raddr), 64'(RESET_PC[63:2]) + 64'(k));
      check("boot_valid", 64'(f_valid), 64'(k >= 2));
      if (k >= 2) check("boot_pc", f_pc, RESET_PC + 64'(4 * (k - 2)));
    end
  endtask

  initial begin
    logic [63:2] held_raddr;
    logic        was_halt;
    d_stall = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    reset_stream(RESET_PC);

    repeat (2) @(negedge clk);
    check("rst_f_valid", 64'(f_valid), 64'd0);
    check("rst_f_pc", f_pc, 64'd0);
    check("rst_f_inst", 64'(f_inst), 64'd0);
    check("rst_raddr", 64'(mem_raddr), 64'(RESET_PC[63:2]));

    // free-run from reset, then a 5-cycle stall at f_pc = 0x8
    release_and_check();
    cyc(); d_stall = 1'b1;
    check("stall_start_pc", f_pc, 64'h8);
    for (int w = 5; w <= 8; w++) begin
      cyc();
      check("stall_pc", f_pc, 64'h8);
      check("stall_count", 64'(dut.fifo_count), 64'd2);
      check("stall_raddr", 64'(mem_raddr), 64'd4);
    end
    cyc(); d_stall = 1'b0;
    check("unstall_pc8", f_pc, 64'h8);
    cyc();
    check("unstall_pcC", f_pc, 64'hC);
    check("unstall_valid", 64'(f_valid), 64'd1);

    // halt at f_pc = 0x10: drain 0x10 and 0x14 only
    cyc(); halt = 1'b1;
    check("halt_pc10", f_pc, 64'h10);
    check("halt_raddr", 64'(mem_raddr), 64'd6);
    cyc();
    check("halt_pc14", f_pc, 64'h14);
    for (int w = 13; w <= 16; w++) begin
      cyc();
      check("halt_empty", 64'(f_valid), 64'd0);
      check("halt_frozen", 64'(mem_raddr), 64'd6);
    end
    cyc(); halt = 1'b0;
    cyc();

    // redirect with stall and a pending push in the same cycle
    cyc();
    check("pre_redir_pc", f_pc, 64'h18);
    check("pre_redir_inflight", 64'(dut.inflight), 64'd1);
    d_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h1000;
    reset_stream(64'h1000);
    cyc(); redirect_valid = 1'b0; d_stall = 1'b0;
    check("redir_empty", 64'(f_valid), 64'd0);
    check("redir_count", 64'(dut.fifo_count), 64'd0);
    check("redir_raddr", 64'(mem_raddr), 64'h400);
    cyc();
    check("redir_gap", 64'(f_valid), 64'd0);
    cyc();
    check("redir_first_valid", 64'(f_valid), 64'd1);
    check("redir_first_pc", f_pc, 64'h1000);

    // redirect with a full buffer; low target bits ignored
    d_stall = 1'b1;
    cyc();
    check("full_before_redir", 64'(dut.fifo_count), 64'd2);
    redirect_valid = 1'b1; redirect_pc = 64'h2003;
    reset_stream(64'h2003);
    cyc(); redirect_valid = 1'b0; d_stall = 1'b0;
    check("redir2_empty", 64'(f_valid), 64'd0);
    check("redir2_raddr", 64'(mem_raddr), 64'h800);
    cyc(); cyc();
    check("redir2_pc", f_pc, 64'h2000);

    // asynchronous reset mid-stream with a full buffer
    cyc(); d_stall = 1'b1;
    cyc();
    check("full_before_rst", 64'(dut.fifo_count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(f_valid), 64'd0);
    check("async_rst_pc", f_pc, 64'd0);
    d_stall = 1'b0;
    reset_stream(RESET_PC);
    release_and_check();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      held_raddr = mem_raddr;
      was_halt = halt && !redirect_valid;
      cyc();
      if (was_halt) check("rand_halt_frozen", 64'(mem_raddr), 64'(held_raddr));
      d_stall = ($urandom_range(0, 99) < 30);
      halt    = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 4) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 3) == 0)
          redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        else
          redirect_pc = {$urandom, $urandom};
        reset_stream(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    cyc();
    d_stall = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
